seq_alu: RTL and testbench

Parametrised, handshaked successor to the single-cycle 4-bit-control ALU: keeps the existing ALUctr operation set and flag semantics, generalises datapath width, and adds the RV32M multiply/divide family executed iteratively over WIDTH cycles. Sits between decode/register-read and writeback in the multi-cycle CPU; all results and flags are registered and returned through a valid/ready output channel.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/mdu_iter.sv | 113 +++++++++++
 rtl/seq_alu.sv | 137 +++++++++++++
 tb/tb_seq_alu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: base ALUctr codes, M-extension codes
// and the control FSM state type.
package alu_pkg;

    localparam int M_BIT = 4;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_PASSB = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b1101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on
// operand magnitudes, one step per cycle, sign fix-up folded into the last step.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             busy,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2:0]         op_q, op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic               a_sgn, b_sgn, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b, hi, lo, diff, quo, rmd;
    logic [WIDTH:0]     rem_try, sum;

    always_comb begin
        a_sgn = op[2] ? ~op[0] : (op == OP_MULH || op == OP_MULHSU);
        b_sgn = op[2] ? ~op[0] : (op == OP_MULH);
        sa    = a_sgn & a[WIDTH-1];
        sb    = b_sgn & b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps the dividend in the low half and shifts quotient bits in.
    always_comb begin
        hi       = acc_q[2*WIDTH-1:WIDTH];
        lo       = acc_q[WIDTH-1:0];
        rem_try  = {hi, lo[WIDTH-1]};
        diff     = rem_try[WIDTH-1:0] - opnd_q;
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
        acc_step = {sum, lo[WIDTH-1:1]};
        if (op_q[2]) begin
            if (rem_try >= {1'b0, opnd_q}) begin
                acc_step = {diff, lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_try[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod   = neg_res_q ? -acc_step : acc_step;
        quo    = acc_step[WIDTH-1:0];
        rmd    = acc_step[2*WIDTH-1:WIDTH];
        result = '0;
        case (op_q)
            OP_MUL:                      result = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             result = neg_res_q ? -quo : quo;
            OP_REM, OP_REMU:             result = neg_rem_q ? -rmd : rmd;
            default:                     result = '0;
        endcase
    end

    assign done = busy & (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        if (start) begin
            acc_d     = {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
            opnd_d    = op[2] ? mag_b : mag_a;
            op_d      = op;
            neg_res_d = sa ^ sb;
            neg_rem_d = sa;
            cnt_d     = '0;
        end else if (busy) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle base ops and M-extension special cases, iterative
// multiply/divide via mdu_iter. Results and flags are registered.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             less,
    output alu_state_e       dbg_state
);

    // Handshake: a transfer happens on any rising edge where valid & ready are both high.
    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, less_q, less_d;

    logic             m_op, is_rsvd, is_divf, div_zero, div_ovf, single, accept;
    logic [3:0]       ctr;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res, sc_res, mdu_res;
    logic             alu_less, alu_cmp, sc_zero, sc_less, mdu_done;

    assign m_op  = op[M_BIT];
    assign ctr   = op[3:0];
    assign shamt = datab[SHW-1:0];

    always_comb begin
        alu_res  = '0;
        alu_less = 1'b0;
        alu_cmp  = 1'b0;
        case (ctr[2:0])
            OP_ADD[2:0]:   alu_res = (ctr == OP_SUB) ? dataa - datab : dataa + datab;
            OP_SLL[2:0]:   alu_res = dataa << shamt;
            OP_SLT[2:0]: begin
                alu_cmp  = 1'b1;
                alu_less = (ctr == OP_SLTU) ? (dataa < datab) : ($signed(dataa) < $signed(datab));
                alu_res  = {{(WIDTH-1){1'b0}}, alu_less};
            end
            OP_PASSB[2:0]: alu_res = datab;
            OP_XOR[2:0]:   alu_res = dataa ^ datab;
            OP_SRL[2:0]:   alu_res = (ctr == OP_SRA) ? WIDTH'($signed(dataa) >>> shamt) : dataa >> shamt;
            OP_OR[2:0]:    alu_res = dataa | datab;
            OP_AND[2:0]:   alu_res = dataa & datab;
            default:       alu_res = '0;
        endcase
    end

    // Divide-by-zero and signed overflow resolve without iterating.
    assign is_rsvd  = m_op & op[3];
    assign is_divf  = m_op & ~op[3] & op[2];
    assign div_zero = is_divf & (datab == '0);
    assign div_ovf  = is_divf & ~op[0] & (dataa == {1'b1, {(WIDTH-1){1'b0}}}) & (datab == '1);
    assign single   = ~m_op | is_rsvd | div_zero | div_ovf;

    always_comb begin
        sc_res  = alu_res;
        sc_less = alu_less;
        sc_zero = alu_cmp ? (dataa == datab) : (alu_res == '0);
        if (m_op) begin
            sc_less = 1'b0;
            if (is_rsvd)       sc_res = '0;
            else if (div_zero) sc_res = op[1] ? dataa : '1;
            else               sc_res = op[1] ? '0 : dataa;
            sc_zero = (sc_res == '0);
        end
    end

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept & ~single),
        .busy   (state_q == S_BUSY),
        .op     (op[2:0]),
        .a      (dataa),
        .b      (datab),
        .done   (mdu_done),
        .result (mdu_res)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        less_d   = less_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = single ? S_DONE : S_BUSY;
            S_BUSY:  if (mdu_done) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = accept ? (single ? S_DONE : S_BUSY) : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept & single) begin
            result_d = sc_res;
            zero_d   = sc_zero;
            less_d   = sc_less;
        end else if (mdu_done) begin
            result_d = mdu_res;
            zero_d   = (mdu_res == '0);
            less_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            less_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            less_q   <= less_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign less      = less_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a vector table for single operations plus
// hand-written sequences for stall, back-to-back issue and reset mid-operation.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op = '0;
    logic [W-1:0] dataa = '0;
    logic [W-1:0] datab = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         less;
    alu_state_e   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic       z;
        logic       l;
        int         cyc;
    } vec_t;

    vec_t vq[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dataa     (dataa),
        .datab     (datab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .less      (less),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [4:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                           input logic l, input int c);
        vec_t v;
        v.name = n; v.op = o; v.a = a; v.b = b; v.res = r; v.z = z; v.l = l; v.cyc = c;
        vq.push_back(v);
    endtask

    // cyc counts the accept cycle as 1: single-cycle ops are visible one cycle
    // after accept, iterative ones WIDTH+1 cycles after accept.
    task automatic run_vec(input vec_t v);
        int guard;
        int lat;
        @(negedge clk);
        op = v.op; dataa = v.a; datab = v.b; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check({v.name, "_accept_timeout"}, 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dataa = $urandom;
        datab = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({v.name, "_cycles"}, 32'(lat), 32'(v.cyc));
        check({v.name, "_result"}, result, v.res);
        check({v.name, "_zero"}, 32'(zero), 32'(v.z));
        check({v.name, "_less"}, 32'(less), 32'(v.l));
    endtask

    initial begin
        bit saw_valid;

        add_vec("add_ovf",    5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1);
        add_vec("add_wrap",   5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
        add_vec("sub_eq",     5'b01000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1);
        add_vec("sub_neg",    5'b01000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        add_vec("slt",        5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1);
        add_vec("sltu",       5'b01010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);
        add_vec("slt_eq",     5'b00010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1);
        add_vec("sra",        5'b01101, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1);
        add_vec("srl",        5'b00101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1);
        add_vec("sll_alias",  5'b01001, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1'b0, 1);
        add_vec("xor",        5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1);
        add_vec("or",         5'b00110, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAFAFAFAF, 1'b0, 1'b0, 1);
        add_vec("and",        5'b00111, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505, 1'b0, 1'b0, 1);
        add_vec("passb",      5'b01011, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1);
        add_vec("mulh",       5'b10001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
        add_vec("mulhu",      5'b10011, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 33);
        add_vec("mul",        5'b10000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0, 1'b0, 33);
        add_vec("mulhsu",     5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
        add_vec("mul_zero",   5'b10000, 32'h00000000, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 33);
        add_vec("div",        5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
        add_vec("rem",        5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
        add_vec("divu",       5'b10101, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0, 33);
        add_vec("remu",       5'b10111, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 1'b0, 33);
        add_vec("divu_by0",   5'b10101, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        add_vec("div_by0",    5'b10100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        add_vec("rem_by0",    5'b10110, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 1'b0, 1);
        add_vec("rem_ovf",    5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1);
        add_vec("div_ovf",    5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1);
        add_vec("reserved",   5'b11000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1);

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_less", 32'(less), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) run_vec(vq[i]);

        // Consumer stall: outputs held, no new accept until out_ready rises
        @(negedge clk);
        op = 5'b00000; dataa = 32'd3; datab = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                op = 5'b00100; dataa = 32'd6; datab = 32'd3; in_valid = 1'b1;
            end
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_result", result, 32'd7);
            check("stall_zero", 32'(zero), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_valid", 32'(out_valid), 32'd1);
        check("release_result", result, 32'd5);

        // Back-to-back single-cycle ops with out_ready held high
        @(negedge clk);
        op = 5'b00000; dataa = 32'd10; datab = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_add", result, 32'd30);
        check("b2b_add_valid", 32'(out_valid), 32'd1);
        op = 5'b01000; dataa = 32'd7; datab = 32'd9;
        @(posedge clk);
        #1;
        check("b2b_sub", result, 32'hFFFFFFFE);
        op = 5'b00111; dataa = 32'hFF; datab = 32'h0F;
        @(posedge clk);
        #1;
        check("b2b_and", result, 32'h0F);
        check("b2b_and_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;

        // Reset during BUSY of a divu aborts it
        @(negedge clk);
        op = 5'b10101; dataa = 32'd1000; datab = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_state", 32'(dbg_state), 32'(S_BUSY));
        check("busy_in_ready", 32'(in_ready), 32'd0);
        check("busy_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(S_IDLE));
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_output", 32'(saw_valid), 32'd0);
        begin
            vec_t v;
            v.name = "post_rst_add"; v.op = 5'b00000; v.a = 32'd2; v.b = 32'd3;
            v.res = 32'd5; v.z = 1'b0; v.l = 1'b0; v.cyc = 1;
            run_vec(v);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
